// File: rtl/id_hazard_issue_ctrl.sv
// id_hazard_issue_ctrl
//   Producer side of the ID/EX pipeline register. It forwards the decoded
//   control bundle into ID/EX, or replaces it with a bubble. A bubble is
//   injected on a load-use hazard, while a taken-branch flush is in progress,
//   and while an external stall is held. The block also gates the PC and
//   IF/ID register writes.
//
//   Parameters
//     FLUSH_CYCLES : bubble cycles inserted after a taken branch (1..7)
//     BUBBLE_MEM   : MEM control value of a bubble
//
//   Ports
//     clk, reset            : clock; synchronous active-low reset
//     dec_*                 : current decode (valid, sources, control bundle)
//     EX_WReg1/EX_*_CTRL    : feedback from the instruction in EX
//     EX_branch_taken       : one-cycle pulse, branch resolved taken
//     ext_stall             : external hold request (level)
//     ID_EX/MEM/WB_CTRL     : control bundle to ID/EX
//     pc_write_en           : PC write enable
//     ifid_write_en         : IF/ID write enable
//     ifid_flush            : IF/ID clear to NOP
//     hazard_state          : RUN=0, FLUSH=1, HOLD=2
//
//   Optional (macro HAZARD_STATS_EN)
//     stall_count           : saturating count of cycles with pc_write_en=0
//     flush_count           : saturating count of cycles with ifid_flush=1
module id_hazard_issue_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [3:0]  BUBBLE_MEM   = 4'hC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_rs1_used,
  input  logic       dec_rs2_used,
  input  logic [5:0] dec_EX_CTRL,
  input  logic [3:0] dec_MEM_CTRL,
  input  logic [2:0] dec_WB_CTRL,
  input  logic [4:0] EX_WReg1,
  input  logic [3:0] EX_MEM_CTRL,
  input  logic [2:0] EX_WB_CTRL,
  input  logic       EX_branch_taken,
  input  logic       ext_stall,
  output logic [5:0] ID_EX_CTRL,
  output logic [3:0] ID_MEM_CTRL,
  output logic [2:0] ID_WB_CTRL,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic [1:0] hazard_state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // The counter holds the number of FLUSH-state cycles that remain. The
  // cycle that triggers the flush is itself the first bubble, so the counter
  // is loaded with FLUSH_CYCLES-1.
  localparam logic [2:0] RELOAD    = 3'(FLUSH_CYCLES - 1);
  localparam state_t     AFTER_BR  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t     state;
  logic [2:0] cnt;
  logic       flush_pending;
  logic       load_use;
  logic       bubble;

  always_comb begin
    load_use = dec_valid && EX_MEM_CTRL[0] && EX_WB_CTRL[0] &&
               (EX_WReg1 != 5'd0) &&
               ((dec_rs1_used && (dec_rs1 == EX_WReg1)) ||
                (dec_rs2_used && (dec_rs2 == EX_WReg1)));
  end

  always_comb begin
    bubble        = 1'b0;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    unique case (state)
      RUN: begin
        if (EX_branch_taken) begin
          bubble        = 1'b1;
          ifid_flush    = 1'b1;
          ifid_write_en = 1'b0;
        end else if (ext_stall || load_use) begin
          bubble        = 1'b1;
          pc_write_en   = 1'b0;
          ifid_write_en = 1'b0;
        end
      end
      FLUSH: begin
        bubble        = 1'b1;
        ifid_flush    = 1'b1;
        ifid_write_en = 1'b0;
      end
      HOLD: begin
        bubble        = 1'b1;
        ifid_write_en = 1'b0;
        // The exit cycle with a branch outstanding behaves like a flush
        // cycle: the wrong-path fetch in IF/ID is cleared and the PC redirects.
        if (!ext_stall && (flush_pending || EX_branch_taken)) begin
          ifid_flush = 1'b1;
        end else begin
          pc_write_en = 1'b0;
        end
      end
      default: begin
        bubble        = 1'b1;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    ID_EX_CTRL   = bubble ? '0         : dec_EX_CTRL;
    ID_MEM_CTRL  = bubble ? BUBBLE_MEM : dec_MEM_CTRL;
    ID_WB_CTRL   = bubble ? '0         : dec_WB_CTRL;
    hazard_state = state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= RUN;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (EX_branch_taken) begin
            cnt   <= RELOAD;
            state <= AFTER_BR;
          end else if (ext_stall) begin
            state <= HOLD;
          end
        end
        FLUSH: begin
          if (EX_branch_taken) begin
            cnt <= RELOAD;
          end else if (cnt <= 3'd1) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        HOLD: begin
          if (ext_stall) begin
            if (EX_branch_taken) flush_pending <= 1'b1;
          end else if (flush_pending || EX_branch_taken) begin
            flush_pending <= 1'b0;
            cnt           <= RELOAD;
            state         <= AFTER_BR;
          end else begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write_en && (stall_count != '1)) stall_count <= stall_count + 16'd1;
      if (ifid_flush && (flush_count != '1))   flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_issue_ctrl.sv
// tb_id_hazard_issue_ctrl
//   Directed-vector bench for id_hazard_issue_ctrl using the default
//   parameters (FLUSH_CYCLES=2, BUBBLE_MEM=4'hC). The inputs are driven 1
//   time unit after each rising edge. The outputs are checked on the
//   following falling edge.
module tb_id_hazard_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rs1, dec_rs2;
  logic       dec_rs1_used, dec_rs2_used;
  logic [5:0] dec_EX_CTRL;
  logic [3:0] dec_MEM_CTRL;
  logic [2:0] dec_WB_CTRL;
  logic [4:0] EX_WReg1;
  logic [3:0] EX_MEM_CTRL;
  logic [2:0] EX_WB_CTRL;
  logic       EX_branch_taken, ext_stall;
  logic [5:0] ID_EX_CTRL;
  logic [3:0] ID_MEM_CTRL;
  logic [2:0] ID_WB_CTRL;
  logic       pc_write_en, ifid_write_en, ifid_flush;
  logic [1:0] hazard_state;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [5:0] DEX  = 6'h2A;
  localparam logic [3:0] DMEM = 4'h6;
  localparam logic [2:0] DWB  = 3'h5;

  always #5 clk = ~clk;

  id_hazard_issue_ctrl #(.FLUSH_CYCLES(2), .BUBBLE_MEM(4'hC)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_EX_CTRL(dec_EX_CTRL), .dec_MEM_CTRL(dec_MEM_CTRL), .dec_WB_CTRL(dec_WB_CTRL),
    .EX_WReg1(EX_WReg1), .EX_MEM_CTRL(EX_MEM_CTRL), .EX_WB_CTRL(EX_WB_CTRL),
    .EX_branch_taken(EX_branch_taken), .ext_stall(ext_stall),
    .ID_EX_CTRL(ID_EX_CTRL), .ID_MEM_CTRL(ID_MEM_CTRL), .ID_WB_CTRL(ID_WB_CTRL),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .hazard_state(hazard_state)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Wait for the falling edge, then compare the whole output set.
  task automatic expect_out(input string tag, input bit bub, input bit pc,
                            input bit we, input bit fl, input logic [1:0] st);
    @(negedge clk);
    check({tag, ".ex"},    32'(ID_EX_CTRL),    bub ? 32'h0 : 32'(DEX));
    check({tag, ".mem"},   32'(ID_MEM_CTRL),   bub ? 32'hC : 32'(DMEM));
    check({tag, ".wb"},    32'(ID_WB_CTRL),    bub ? 32'h0 : 32'(DWB));
    check({tag, ".pc"},    32'(pc_write_en),   32'(pc));
    check({tag, ".we"},    32'(ifid_write_en), 32'(we));
    check({tag, ".flush"}, 32'(ifid_flush),    32'(fl));
    check({tag, ".state"}, 32'(hazard_state),  32'(st));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    EX_MEM_CTRL = 4'h1;
    EX_WB_CTRL  = 3'h1;
    EX_WReg1    = rd;
  endtask

  task automatic clear_ex();
    EX_MEM_CTRL = 4'hC;
    EX_WB_CTRL  = 3'h0;
    EX_WReg1    = 5'd0;
  endtask

  initial begin
    reset = 1'b0; dec_valid = 1'b1;
    dec_rs1 = 5'd3; dec_rs2 = 5'd5; dec_rs1_used = 1'b1; dec_rs2_used = 1'b1;
    dec_EX_CTRL = DEX; dec_MEM_CTRL = DMEM; dec_WB_CTRL = DWB;
    EX_branch_taken = 1'b0; ext_stall = 1'b0;
    clear_ex();

    // Reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    expect_out("reset", 0, 1, 1, 0, 2'd0);

    // Load-use on rs2: one bubble, then the bubble clears the hazard.
    next_cycle(); dec_rs1_used = 1'b0; set_load(5'd5);
    expect_out("lu", 1, 0, 0, 0, 2'd0);
    next_cycle(); clear_ex();
    expect_out("lu_after", 0, 1, 1, 0, 2'd0);
    // A matching x0 destination is not a hazard.
    next_cycle(); dec_rs2 = 5'd0; set_load(5'd0);
    expect_out("lu_x0", 0, 1, 1, 0, 2'd0);
    // A decode slot without a valid instruction is not a hazard.
    next_cycle(); dec_rs2 = 5'd5; set_load(5'd5); dec_valid = 1'b0;
    expect_out("lu_invalid", 0, 1, 1, 0, 2'd0);
    next_cycle(); dec_valid = 1'b1; clear_ex();

    // Branch: two flush cycles, then RUN.
    EX_branch_taken = 1'b1;
    expect_out("br0", 1, 1, 0, 1, 2'd0);
    next_cycle(); EX_branch_taken = 1'b0;
    expect_out("br1", 1, 1, 0, 1, 2'd1);
    next_cycle();
    expect_out("br_done", 0, 1, 1, 0, 2'd0);

    // Priority: branch beats ext_stall and load-use.
    next_cycle(); EX_branch_taken = 1'b1; ext_stall = 1'b1; set_load(5'd5);
    expect_out("prio", 1, 1, 0, 1, 2'd0);
    next_cycle(); EX_branch_taken = 1'b0; ext_stall = 1'b0; clear_ex();
    expect_out("prio_fl", 1, 1, 0, 1, 2'd1);
    next_cycle();
    expect_out("prio_done", 0, 1, 1, 0, 2'd0);

    // Hold with a pending branch.
    next_cycle(); ext_stall = 1'b1;
    expect_out("hold1", 1, 0, 0, 0, 2'd0);
    next_cycle(); EX_branch_taken = 1'b1;
    expect_out("hold2", 1, 0, 0, 0, 2'd2);
    next_cycle(); EX_branch_taken = 1'b0;
    expect_out("hold3", 1, 0, 0, 0, 2'd2);
    next_cycle();
    expect_out("hold4", 1, 0, 0, 0, 2'd2);
    next_cycle(); ext_stall = 1'b0;
    expect_out("hold_exit", 1, 1, 0, 1, 2'd2);
    next_cycle();
    expect_out("hold_fl", 1, 1, 0, 1, 2'd1);
    next_cycle();
    expect_out("hold_done", 0, 1, 1, 0, 2'd0);

    // Hold without a pending branch returns straight to RUN.
    next_cycle(); ext_stall = 1'b1;
    expect_out("hnp1", 1, 0, 0, 0, 2'd0);
    next_cycle(); ext_stall = 1'b0;
    expect_out("hnp_exit", 1, 0, 0, 0, 2'd2);
    next_cycle();
    expect_out("hnp_done", 0, 1, 1, 0, 2'd0);

    // A branch during FLUSH reloads the counter.
    next_cycle(); EX_branch_taken = 1'b1;
    expect_out("rl0", 1, 1, 0, 1, 2'd0);
    next_cycle();
    expect_out("rl1", 1, 1, 0, 1, 2'd1);
    next_cycle(); EX_branch_taken = 1'b0;
    expect_out("rl2", 1, 1, 0, 1, 2'd1);
    next_cycle();
    expect_out("rl_done", 0, 1, 1, 0, 2'd0);

    // Reset in the first FLUSH cycle.
    next_cycle(); EX_branch_taken = 1'b1;
    expect_out("rf0", 1, 1, 0, 1, 2'd0);
    next_cycle(); EX_branch_taken = 1'b0; reset = 1'b0;
    expect_out("rf1", 1, 1, 0, 1, 2'd1);
    next_cycle(); reset = 1'b1;
    expect_out("rf_run", 0, 1, 1, 0, 2'd0);
    next_cycle();
    expect_out("rf_run2", 0, 1, 1, 0, 2'd0);

`ifdef HAZARD_STATS_EN
    @(negedge clk);
    check("stats.flush0", 32'(flush_count), 32'h0);
    check("stats.stall0", 32'(stall_count), 32'h0);
    // Three stall cycles plus one HOLD-exit cycle keep the PC frozen.
    next_cycle(); ext_stall = 1'b1;
    next_cycle(); next_cycle();
    next_cycle(); ext_stall = 1'b0;
    next_cycle();
    @(negedge clk);
    check("stats.stall4", 32'(stall_count), 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_hazard_issue_ctrl.md
Name: id_hazard_issue_ctrl

Overview:
- Producer side of the ID/EX pipeline register: drives the ID_EX_CTRL/ID_MEM_CTRL/ID_WB_CTRL bundle into ID/EX and gates PC and IF/ID writes.
- Compares the current decode against the EX-stage feedback (EX_WReg1, EX_MEM_CTRL, EX_WB_CTRL).
- Injects bubbles on load-use hazards, on taken-branch flushes, and while an external stall is held (e.g. FIFO back-pressure).

Parameters:
FLUSH_CYCLES, 2, number of bubble cycles inserted after a taken branch (1..7)
BUBBLE_MEM, 4'hC, MEM_CTRL value of a bubble (same as the ID/EX reset value)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low; sampled on rising clk edge
dec_valid  input  1  decode holds a real instruction
dec_rs1  input  5  source register 1
dec_rs2  input  5  source register 2
dec_rs1_used  input  1  rs1 read by this instruction
dec_rs2_used  input  1  rs2 read by this instruction
dec_EX_CTRL  input  6  decoded EX control
dec_MEM_CTRL  input  4  decoded MEM control; bit0 = memory read (load)
dec_WB_CTRL  input  3  decoded WB control; bit0 = register write enable
EX_WReg1  input  5  destination register of the instruction in EX
EX_MEM_CTRL  input  4  MEM control of the instruction in EX
EX_WB_CTRL  input  3  WB control of the instruction in EX
EX_branch_taken  input  1  one-cycle pulse, branch resolved taken in EX
ext_stall  input  1  external hold request, level
ID_EX_CTRL  output  6  EX control to ID/EX
ID_MEM_CTRL  output  4  MEM control to ID/EX
ID_WB_CTRL  output  3  WB control to ID/EX
pc_write_en  output  1  PC may advance
ifid_write_en  output  1  IF/ID may load
ifid_flush  output  1  IF/ID clears to NOP
hazard_state  output  2  current FSM state (RUN=0, FLUSH=1, HOLD=2)

Behaviour:
- Only state element is clk with a synchronous active-low reset. reset=0 at a rising edge sets state=RUN, flush counter=0, flush_pending=0, and (optional) counters=0.
- Reset mid-FLUSH or mid-HOLD returns to RUN on the next edge; any pending flush is discarded.
- Outputs are combinational from registered state plus current inputs, so a bubble takes effect in the same cycle it is decided.
- Bubble value: ID_EX_CTRL=0, ID_MEM_CTRL=BUBBLE_MEM, ID_WB_CTRL=0. Otherwise the outputs pass dec_* through.
- load_use is true when all of the following hold:
  - dec_valid
  - EX_MEM_CTRL[0]=1 and EX_WB_CTRL[0]=1
  - EX_WReg1 != 0
  - (dec_rs1_used and dec_rs1==EX_WReg1) or (dec_rs2_used and dec_rs2==EX_WReg1)
- RUN:
  - EX_branch_taken: bubble, ifid_flush=1, pc_write_en=1, ifid_write_en=0. Load counter with FLUSH_CYCLES-1; go to FLUSH, or stay in RUN if FLUSH_CYCLES=1.
  - else ext_stall: bubble, pc_write_en=0, ifid_write_en=0; go to HOLD.
  - else load_use: bubble, pc_write_en=0, ifid_write_en=0; stay in RUN. The bubble clears the hazard next cycle, so the stall is exactly 1 cycle.
  - else: pass-through, pc_write_en=1, ifid_write_en=1.
- FLUSH:
  - Each cycle: bubble, ifid_flush=1, pc_write_en=1, ifid_write_en=0; decrement the counter.
  - Counter 0 → go to RUN.
  - EX_branch_taken during FLUSH reloads the counter to FLUSH_CYCLES-1.
  - ext_stall during FLUSH is ignored until the state returns to RUN.
- HOLD:
  - Each cycle: bubble, pc_write_en=0, ifid_write_en=0, ifid_flush=0.
  - EX_branch_taken in HOLD sets flush_pending.
  - ext_stall=0 with flush_pending=1 → go to FLUSH (counter=FLUSH_CYCLES-1), clear flush_pending, and assert ifid_flush that cycle.
  - ext_stall=0 with flush_pending=0 → go to RUN.
- Priority in RUN when events coincide: branch > ext_stall > load_use.
- dec_valid=0 in RUN: pass-through of whatever the decoder drives; the decoder emits NOP controls.
- ifid_flush and ifid_write_en are never both 1.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, add outputs stall_count[15:0] and flush_count[15:0]:
  - stall_count increments on every cycle with pc_write_en=0.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 clks with dec_* nonzero, then release → hazard_state=0; pass-through on the outputs; pc_write_en=1, ifid_write_en=1, ifid_flush=0.
- Load-use: EX_MEM_CTRL=4'h1, EX_WB_CTRL=3'h1, EX_WReg1=5; dec_rs2=5, dec_rs2_used=1 → 1 cycle with ID_MEM_CTRL=4'hC and pc_write_en=0. Repeat with EX_WReg1=0 → no stall.
- Branch: pulse EX_branch_taken for 1 clk in RUN with FLUSH_CYCLES=2 → exactly 2 cycles of ifid_flush=1 with bubble outputs, then RUN.
- Priority: EX_branch_taken, ext_stall and load_use all 1 in the same cycle → branch wins: FLUSH entered, pc_write_en=1, ifid_flush=1.
- Hold with pending branch: ext_stall=1 for 4 clks with an EX_branch_taken pulse at clk 2 → 4 cycles of pc_write_en=0; then the HOLD-exit cycle plus 1 FLUSH cycle with ifid_flush=1 (2 total); then RUN.
- Reset mid-FLUSH: assert reset=0 in the 1st FLUSH cycle → RUN on the next edge, no further ifid_flush. With HAZARD_STATS_EN, flush_count=0 after reset and saturates at 16'hFFFF under a continuous ext_stall driven into stall_count.
